// File: rtl/aes_pkg.sv
// Shared AES package: default block/byte widths and the result-serializer FSM encoding,
// common to the AES core, host controller and aes_result_ser.
package aes_pkg;

    localparam int AES_DW_DEF = 128;
    localparam int BYTE_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_CSUM = 2'd2;

endpackage

// File: rtl/aes_result_ser.sv
// Serialises an AES result block into bytes (MSB-first) with a valid/ready handshake.
// Define AES_SER_CHECKSUM_EN to append an XOR checksum byte after each block.
module aes_result_ser
    import aes_pkg::*;
#(
    parameter int AES_DW = AES_DW_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:AES_DW-1]   blk_i,
    input  logic                blk_valid_i,
    output logic [BYTE_W-1:0]   byte_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
    output logic                busy_o,
    output logic                overrun_o,
    input  logic                clr_overrun_i
);

    localparam int NBYTES = AES_DW / BYTE_W;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]        state;
    logic [0:AES_DW-1] shreg;
    logic [IDX_W-1:0]  idx;
    logic              overrun;
    logic [BYTE_W-1:0] cur;
    logic              xfer;
    logic              final_xfer;
    logic              ovr_set;
`ifdef AES_SER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
`endif

    assign cur          = shreg[0 +: BYTE_W];
    assign byte_valid_o = (state != ST_IDLE);
    assign busy_o       = (state != ST_IDLE);
    assign overrun_o    = overrun;
    assign xfer         = byte_valid_o && byte_ready_i;

`ifdef AES_SER_CHECKSUM_EN
    assign final_xfer = xfer && (state == ST_CSUM);
`else
    assign final_xfer = xfer && (state == ST_SEND) && (idx == LAST_IDX);
`endif

    // A block arriving on the closing handshake is a legal back-to-back load, not an overrun.
    assign ovr_set = blk_valid_i && (state != ST_IDLE) && !final_xfer;

    always_comb begin
        byte_o = '0;
        if (state == ST_SEND) begin
            byte_o = cur;
        end
`ifdef AES_SER_CHECKSUM_EN
        else if (state == ST_CSUM) begin
            byte_o = csum;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            idx     <= '0;
            overrun <= 1'b0;
`ifdef AES_SER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun_i) begin
                overrun <= 1'b0;
            end

            if (final_xfer && blk_valid_i) begin
                state <= ST_SEND;
                shreg <= blk_i;
                idx   <= '0;
`ifdef AES_SER_CHECKSUM_EN
                csum  <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (blk_valid_i) begin
                            state <= ST_SEND;
                            shreg <= blk_i;
                            idx   <= '0;
`ifdef AES_SER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                    ST_SEND: begin
                        if (xfer) begin
                            shreg <= shreg << BYTE_W;
`ifdef AES_SER_CHECKSUM_EN
                            csum  <= csum ^ cur;
                            idx   <= idx + 1'b1;
                            if (idx == LAST_IDX) begin
                                state <= ST_CSUM;
                            end
`else
                            if (idx == LAST_IDX) begin
                                state <= ST_IDLE;
                                idx   <= '0;
                            end else begin
                                idx   <= idx + 1'b1;
                            end
`endif
                        end
                    end
`ifdef AES_SER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (xfer) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/aes_result_ser.md
AES_RESULT_SER -- requirements
Module: aes_result_ser

Interface
REQ-001 SHALL have parameter AES_DW, default 128, meaning result block width in bits (multiple of 8).
REQ-002 SHALL have parameter BYTE_W, default 8, meaning output byte width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port blk_i  input  [0:AES_DW-1]  AES result block, bit 0 = MSB of first byte.
REQ-006 SHALL have port blk_valid_i  input  1  one-cycle pulse qualifying blk_i (AES core valid).
REQ-007 SHALL have port byte_o  output  BYTE_W  byte toward UART TX path.
REQ-008 SHALL have port byte_valid_o  output  1  byte_o valid.
REQ-009 SHALL have port byte_ready_i  input  1  consumer accepts byte_o.
REQ-010 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port overrun_o  output  1  sticky flag, a block was dropped.
REQ-012 SHALL have port clr_overrun_i  input  1  clears overrun_o.

Function
REQ-013 SHALL use FSM states IDLE, SEND, CSUM (CSUM only when the REQ-027 macro is defined).
REQ-014 SHALL, in IDLE on blk_valid_i, capture blk_i into a shift register, clear the byte index, and enter SEND.
REQ-015 SHALL assert byte_valid_o the cycle after capture; capture-to-first-byte latency is 1 cycle.
REQ-016 SHALL present bytes MSB-first: byte k = blk_i[8k:8k+7], k = 0..AES_DW/8-1.
REQ-017 SHALL count a transfer only in a cycle with byte_valid_o and byte_ready_i both high; it then shifts the register by BYTE_W and increments the index.
REQ-018 SHALL hold byte_o and byte_valid_o stable while byte_ready_i is low; byte_valid_o never deasserts before a transfer.
REQ-019 SHALL, on the transfer with index = AES_DW/8-1, go to CSUM if enabled, else IDLE.
REQ-020 SHALL, when blk_valid_i coincides with the final transfer (last data byte, or checksum byte if enabled), capture the new block and re-enter SEND at index 0 with no idle cycle and no overrun.
REQ-021 SHALL, on blk_valid_i in any other non-IDLE cycle, drop that block, set overrun_o, and leave the ongoing transfer unaffected.
REQ-022 SHALL clear overrun_o on clr_overrun_i; a simultaneous set wins.
REQ-023 SHALL drive byte_o = 0 whenever byte_valid_o is low.
REQ-024 SHALL size the index counter to clog2(AES_DW/BYTE_W + 1) bits; no wrap-around occurs inside a block.

Reset
REQ-025 SHALL reset, on rst_n low: state IDLE, byte_o 0, byte_valid_o 0, busy_o 0, overrun_o 0, index 0, shift register 0, checksum 0.
REQ-026 SHALL, on reset mid-transfer, abandon the block with no residual output after release.

Configuration
REQ-027 SHALL, with AES_SER_CHECKSUM_EN defined, accumulate the XOR of all data bytes as they transfer and send it as one extra byte in CSUM, using the same handshake; the accumulator clears on capture.
REQ-028 SHALL, without AES_SER_CHECKSUM_EN, have no CSUM state or accumulator logic; exactly AES_DW/8 bytes are sent per block.

Structure
REQ-029 SHALL take AES_DW/BYTE_W defaults and the FSM state encoding from the shared aes_pkg package, together with the AES core and host controller.
REQ-030 SHALL be implemented flat; no sub-module.

Verification
REQ-031 SHALL cover: blk_i = 128'h69c4e0d86a7b0430d8cdb78070b4c55a, byte_ready_i held high -> bytes 69,c4,e0,...,c5,5a on 16 consecutive cycles, then busy_o low.
REQ-032 SHALL cover: byte_ready_i low for 5 cycles while byte 3 (d8) is presented -> byte_o = d8 and byte_valid_o high are held for all 5 cycles, with no skipped or duplicated bytes.
REQ-033 SHALL cover: a second blk_valid_i at byte index 7 -> overrun_o = 1, the first block completes intact, and the second block is never sent; clr_overrun_i with no new set -> overrun_o = 0.
REQ-034 SHALL cover: blk_valid_i coincident with the final transfer -> the next block's byte 0 appears the following cycle and overrun_o stays 0.
REQ-035 SHALL cover: rst_n low at byte index 9 -> all outputs are 0 on the next edge; a block after release is sent from byte 0.
REQ-036 SHALL cover, with AES_SER_CHECKSUM_EN: blk_i = all-ones -> 16 bytes of ff followed by checksum byte 00; blk_i = 0x01 followed by zeros -> checksum byte 01.
